// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash ID responder: FSM states,
// recognised opcodes and the default ID bytes returned to the master.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } state_t;

  localparam int         BYTE_BITS     = 8;
  localparam int         DEF_ADDR_BITS = 24;

  localparam logic [7:0] CMD_RDID  = 8'h90;
  // Reserved for the JEDEC ID extension; not decoded yet.
  localparam logic [7:0] CMD_JEDEC = 8'h9F;

  localparam logic [7:0] DEF_MFR_ID = 8'hEF;
  localparam logic [7:0] DEF_DEV_ID = 8'h17;

  // 16-bit ID word in shift-out order; the swap flag is address bit 0.
  function automatic logic [15:0] id_word(input logic [7:0] mfr,
                                          input logic [7:0] dev,
                                          input logic       swap);
    return swap ? {dev, mfr} : {mfr, dev};
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous SPI pins into the sys_clk domain and derives
// one-cycle edge strobes for chip select and SCLK.
module spi_slave_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic cs_fall,
  output logic cs_rise,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s
);

  // [0],[1] are the synchronizer stages, [2] is the edge-detect history.
  logic [2:0] cs_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: chip select resets to the asserted level so a CS_n already low
      // at reset release produces no fall strobe; a fresh rise must come first.
      cs_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sclk_q <= {sclk_q[1:0], spi_sclk};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  assign cs_n_s    = cs_q[1];
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_flash_id_responder.sv
// SPI slave answering the 0x90 Manufacturer/Device ID read like a serial NOR
// flash; all pins are oversampled in sys_clk, no SCLK-derived clock exists.
module spi_flash_id_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] MFR_ID    = DEF_MFR_ID,
  parameter logic [7:0] DEV_ID    = DEF_DEV_ID,
  parameter int         ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       busy,
  output logic       id_sent,
  output logic       bad_cmd,
  output logic [7:0] last_cmd
);

  localparam logic [5:0] LAST_CMD_BIT = 6'(BYTE_BITS - 1);
  localparam logic [5:0] LAST_HDR_BIT = 6'(BYTE_BITS + ADDR_BITS - 1);

  logic cs_n_s, cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

  spi_slave_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .cs_n_s    (cs_n_s),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s)
  );

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [3:0]  data_cnt;
  logic [7:0]  cmd_sr;
  logic        swap;
  logic [7:0]  cmd_next;
  logic [15:0] word;
  logic        shift_in;
  logic        shift_out;

  // SCLK edges only matter while the synchronized select is asserted.
  assign shift_in  = sclk_rise & ~cs_n_s;
  assign shift_out = sclk_fall & ~cs_n_s;
  assign cmd_next  = {cmd_sr[BYTE_BITS-2:0], mosi_s};
  assign word      = id_word(MFR_ID, DEV_ID, swap);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      data_cnt    <= '0;
      cmd_sr      <= '0;
      swap        <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      id_sent     <= 1'b0;
      bad_cmd     <= 1'b0;
      last_cmd    <= '0;
    end else begin
      id_sent <= 1'b0;
      bad_cmd <= 1'b0;
      // Deselect overrides everything, including an SCLK strobe in the same cycle.
      if (cs_rise) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        data_cnt    <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              busy     <= 1'b1;
              bit_cnt  <= '0;
              data_cnt <= '0;
              cmd_sr   <= '0;
              swap     <= 1'b0;
            end
          end
          CMD: begin
            if (shift_in) begin
              cmd_sr  <= cmd_next;
              bit_cnt <= bit_cnt + 6'd1;
              if (bit_cnt == LAST_CMD_BIT) begin
                last_cmd <= cmd_next;
                if (cmd_next == CMD_RDID) begin
                  state <= ADDR;
                end else begin
                  bad_cmd <= 1'b1;
                  state   <= IGNORE;
                end
              end
            end
          end
          ADDR: begin
            if (shift_in) begin
              // Each address bit overwrites the flag, so bit 0 is what remains.
              swap <= mosi_s;
              if (bit_cnt == LAST_HDR_BIT) begin
                bit_cnt <= '0;
                state   <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          DATA: begin
            if (shift_out) begin
              spi_miso_oe <= 1'b1;
              // ~data_cnt walks the word MSB first and wraps to replay it.
              spi_miso    <= word[~data_cnt];
              data_cnt    <= data_cnt + 4'd1;
              if (data_cnt == 4'd15) id_sent <= 1'b1;
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Self-checking bench: table of directed transactions, hand sequences for
// abort/reset/bad-opcode timing, and random transactions against a model.
module tb_spi_flash_id_responder;

  localparam int HALF = 5;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       spi_cs_n  = 1'b1;
  logic       spi_sclk  = 1'b0;
  logic       spi_mosi  = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       busy;
  logic       id_sent;
  logic       bad_cmd;
  logic [7:0] last_cmd;

  int checks = 0;
  int errors = 0;
  int id_pulses = 0;
  int bad_pulses = 0;

  spi_flash_id_responder dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .id_sent     (id_sent),
    .bad_cmd     (bad_cmd),
    .last_cmd    (last_cmd)
  );

  always #10 sys_clk = ~sys_clk;

  // Counts high cycles, so a stuck pulse shows up as an excess count.
  always @(negedge sys_clk) begin
    if (id_sent === 1'b1) id_pulses++;
    if (bad_cmd === 1'b1) bad_pulses++;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic        mode3;
    logic [7:0]  op;
    logic [23:0] addr;
    int          nread;
    logic [63:0] exp_rd;
    int          exp_id;
    int          exp_bad;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_half();
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic start_xfer(input logic mode3);
    spi_sclk = mode3;
    wait_half();
    spi_cs_n = 1'b0;
    wait_half();
  endtask

  // Falling edge, new MOSI, half period, sample MISO, rising edge.
  task automatic clk_bit(input logic b, output logic m, output logic oe);
    spi_sclk = 1'b0;
    spi_mosi = b;
    wait_half();
    m  = spi_miso;
    oe = spi_miso_oe;
    spi_sclk = 1'b1;
  endtask

  task automatic end_xfer(input logic mode3);
    wait_half();
    spi_sclk = mode3;
    wait_half();
    spi_cs_n = 1'b1;
    wait_half();
    wait_half();
  endtask

  task automatic xfer(input logic mode3, input logic [7:0] op, input logic [23:0] addr,
                      input int nread, output logic [63:0] rd, output logic hdr_oe,
                      output logic rd_oe_all, output logic rd_oe_any);
    logic [31:0] hdr;
    logic m, oe;
    hdr = {op, addr};
    hdr_oe = 1'b0;
    rd = '0;
    rd_oe_all = 1'b1;
    rd_oe_any = 1'b0;
    start_xfer(mode3);
    for (int i = 31; i >= 0; i--) begin
      clk_bit(hdr[i], m, oe);
      wait_half();
      hdr_oe |= spi_miso_oe;
    end
    for (int i = 0; i < nread; i++) begin
      clk_bit(1'b0, m, oe);
      rd = {rd[62:0], m};
      rd_oe_all &= oe;
      rd_oe_any |= oe;
      wait_half();
    end
    end_xfer(mode3);
  endtask

  // Reference: the ID word in its selected byte order, repeated bit by bit.
  function automatic logic [63:0] model_read(input logic [23:0] addr, input int n);
    logic [15:0] w;
    logic [63:0] r;
    w = addr[0] ? 16'h17EF : 16'hEF17;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], w[15 - (i % 16)]};
    return r;
  endfunction

  task automatic run_case(input vec_t v);
    logic [63:0] rd;
    logic hdr_oe, rd_all, rd_any;
    logic good;
    int id0, bad0;
    id0  = id_pulses;
    bad0 = bad_pulses;
    good = (v.exp_bad == 0);
    xfer(v.mode3, v.op, v.addr, v.nread, rd, hdr_oe, rd_all, rd_any);
    check($sformatf("%s read data", v.name), rd, v.exp_rd);
    check($sformatf("%s oe during header", v.name), 64'(hdr_oe), 64'd0);
    check($sformatf("%s oe during read", v.name), {62'd0, rd_all, rd_any},
          good ? {62'd0, 1'b1, v.nread > 0} : {62'd0, v.nread == 0, 1'b0});
    check($sformatf("%s id_sent pulses", v.name), 64'(id_pulses - id0), 64'(v.exp_id));
    check($sformatf("%s bad_cmd pulses", v.name), 64'(bad_pulses - bad0), 64'(v.exp_bad));
    check($sformatf("%s last_cmd/busy", v.name), {55'd0, last_cmd, busy}, {55'd0, v.op, 1'b0});
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    logic m, oe, seen;
    logic [31:0] hdr;
    int id0;

    vecs[0] = '{"m3_addr0",   1'b1, 8'h90, 24'h000000, 16, 64'hEF17,     1, 0};
    vecs[1] = '{"m3_addr1",   1'b1, 8'h90, 24'h000001, 16, 64'h17EF,     1, 0};
    vecs[2] = '{"m0_x32",     1'b0, 8'h90, 24'h000000, 32, 64'hEF17EF17, 2, 0};
    vecs[3] = '{"m3_op9f",    1'b1, 8'h9F, 24'h123456, 16, 64'h0,        0, 1};
    vecs[4] = '{"m0_odd_len", 1'b0, 8'h90, 24'hABCDEF, 20, 64'h17EF1,    1, 0};

    repeat (3) @(negedge sys_clk);
    check("reset outputs", {51'd0, spi_miso, spi_miso_oe, busy, id_sent, bad_cmd, last_cmd}, 64'd0);
    sys_rst_n = 1'b1;
    wait_half();

    for (int i = 0; i < 5; i++) run_case(vecs[i]);

    // bad_cmd timing: pulse lands 3 cycles after the 8th rise, one cycle wide.
    start_xfer(1'b1);
    hdr = {8'h9F, 24'h0};
    for (int i = 31; i >= 24; i--) begin
      if (i != 31) wait_half();
      clk_bit(hdr[i], m, oe);
    end
    repeat (2) @(posedge sys_clk);
    #1 check("bad_cmd before 3rd cycle", 64'(bad_cmd), 64'd0);
    @(posedge sys_clk);
    #1 check("bad_cmd at 3rd cycle", {55'd0, bad_cmd, last_cmd}, {55'd0, 1'b1, 8'h9F});
    @(posedge sys_clk);
    #1 check("bad_cmd one cycle wide", 64'(bad_cmd), 64'd0);
    @(negedge sys_clk);
    end_xfer(1'b1);

    // Deselect mid-address, then a clean transaction.
    start_xfer(1'b1);
    hdr = {8'h90, 24'h0};
    for (int i = 31; i >= 12; i--) begin
      clk_bit(hdr[i], m, oe);
      wait_half();
    end
    check("busy mid-address", 64'(busy), 64'd1);
    spi_cs_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 check("abort clears busy/oe", {62'd0, busy, spi_miso_oe}, 64'd0);
    @(negedge sys_clk);
    spi_sclk = 1'b1;
    wait_half();
    v = vecs[0];
    v.name = "after_abort";
    run_case(v);

    // Reset asserted during DATA bit 5, then CS_n held low across release.
    start_xfer(1'b0);
    for (int i = 31; i >= 0; i--) begin
      clk_bit(hdr[i], m, oe);
      wait_half();
    end
    for (int i = 0; i < 5; i++) begin
      clk_bit(1'b0, m, oe);
      wait_half();
    end
    check("in DATA before reset", {62'd0, busy, spi_miso_oe}, {62'd0, 2'b11});
    #3 sys_rst_n = 1'b0;
    #1 check("async reset outputs",
             {51'd0, spi_miso, spi_miso_oe, busy, id_sent, bad_cmd, last_cmd}, 64'd0);
    @(negedge sys_clk);
    spi_sclk = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_half();
    id0  = id_pulses;
    seen = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      clk_bit(hdr[i], m, oe);
      wait_half();
      seen |= busy | spi_miso_oe | spi_miso;
    end
    for (int i = 0; i < 16; i++) begin
      clk_bit(1'b0, m, oe);
      wait_half();
      seen |= busy | spi_miso_oe | spi_miso;
    end
    check("no response with CS_n low at release", {63'd0, seen}, 64'd0);
    check("no id_sent with CS_n low at release", 64'(id_pulses - id0), 64'd0);
    end_xfer(1'b0);
    v = vecs[0];
    v.name = "after_reset";
    run_case(v);

    // Random transactions against the model.
    for (int k = 0; k < 16; k++) begin
      v.name  = $sformatf("rnd%0d", k);
      v.mode3 = 1'($urandom_range(0, 1));
      v.op    = ($urandom_range(0, 1) == 1) ? 8'h90 : 8'($urandom);
      v.addr  = 24'($urandom);
      v.nread = int'($urandom_range(0, 40));
      if (v.op == 8'h90) begin
        v.exp_rd  = model_read(v.addr, v.nread);
        v.exp_id  = (v.nread + (v.mode3 ? 0 : 1)) / 16;
        v.exp_bad = 0;
      end else begin
        v.exp_rd  = '0;
        v.exp_id  = 0;
        v.exp_bad = 1;
      end
      run_case(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
